apb_channel_register_bank: RTL and testbench

Parametrised APB register bank serving `CHANNELS` identical control channels. Each channel has a double-buffered control field with commit, a read-only status field, a sticky write-1-to-clear event field, and an interrupt enable. It sits between the APB fabric and per-channel datapath logic. It replaces fixed-shape generated register blocks with one channel-scalable block that adds shadow/commit, W1C events, interrupts and error responses.

---
 rtl/apb_channel_register_bank.sv | 178 +++++++++++++++++
 tb/tb_apb_channel_register_bank.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_channel_register_bank.sv
// apb_channel_register_bank: APB register bank for CHANNELS identical control
// channels. Each channel has a shadow CTRL with commit into an active copy, a
// read-only STATUS, a sticky write-1-to-clear EVENT and an interrupt enable.
//
// Handshake: a transfer is requested when i_psel & i_penable are seen in IDLE.
// The bank answers with exactly one wait state: the following cycle (RESP)
// holds o_pready=1 with registered o_prdata/o_pslverr. The master must keep
// i_psel high through RESP; a write commits on the edge that leaves RESP and
// is dropped if i_psel has fallen by then.
module apb_channel_register_bank #(
    parameter int CHANNELS = 4,
    parameter int FIELD_WIDTH = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter logic [FIELD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_psel,
    input  logic                                  i_penable,
    input  logic                                  i_pwrite,
    input  logic [ADDRESS_WIDTH-1:0]              i_paddr,
    input  logic [31:0]                           i_pwdata,
    output logic                                  o_pready,
    output logic [31:0]                           o_prdata,
    output logic                                  o_pslverr,
    output logic [CHANNELS-1:0][FIELD_WIDTH-1:0]  o_value,
    input  logic [CHANNELS-1:0][FIELD_WIDTH-1:0]  i_status,
    input  logic [CHANNELS-1:0][FIELD_WIDTH-1:0]  i_event,
    input  logic [CHANNELS-1:0]                   i_commit,
    output logic [CHANNELS-1:0]                   o_irq,
    output logic [0:0]                            o_state
);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_RESP = 1'b1;

    localparam logic [ADDRESS_WIDTH-1:0] COMMIT_ADDR   = ADDRESS_WIDTH'(CHANNELS * 16);
    localparam logic [ADDRESS_WIDTH-1:0] CHANNEL_COUNT = ADDRESS_WIDTH'(CHANNELS);
    // Only the field bits and the commit bits of the write data matter.
    localparam int KEEP_WIDTH = (FIELD_WIDTH > CHANNELS) ? FIELD_WIDTH : CHANNELS;

    logic [0:0] state;

    logic [CHANNELS-1:0][FIELD_WIDTH-1:0] shadow;
    logic [CHANNELS-1:0][FIELD_WIDTH-1:0] active;
    logic [CHANNELS-1:0][FIELD_WIDTH-1:0] evt;
    logic [CHANNELS-1:0][FIELD_WIDTH-1:0] int_en;

    // Decode of the live APB address, used at the edge that enters RESP.
    logic [ADDRESS_WIDTH-1:0] dec_index;
    logic                     dec_aligned;
    logic                     dec_commit;
    logic                     dec_chan;
    logic [3:0]               dec_ch;
    logic [1:0]               dec_off;
    logic [31:0]              rd_data;

    // Request captured on entry to RESP and applied on exit.
    logic                  req_write;
    logic                  req_chan;
    logic                  req_commit;
    logic [3:0]            req_ch;
    logic [1:0]            req_off;
    logic [KEEP_WIDTH-1:0] req_wdata;

    logic                                 wr_fire;
    logic [CHANNELS-1:0]                  chan_hit;
    logic [CHANNELS-1:0]                  wr_ctrl;
    logic [CHANNELS-1:0]                  wr_int_en;
    logic [CHANNELS-1:0]                  commit_now;
    logic [CHANNELS-1:0][FIELD_WIDTH-1:0] evt_clear;

    logic unused_pwdata;
    assign unused_pwdata = ^i_pwdata;

    assign o_pready = (state == STATE_RESP);
    assign o_state  = state;
    assign o_value  = active;

    // Address decode: channel window, global COMMIT, everything else errors.
    always_comb begin
        dec_index   = i_paddr >> 4;
        dec_aligned = (i_paddr[1:0] == 2'b00);
        dec_commit  = dec_aligned && (i_paddr == COMMIT_ADDR);
        dec_chan    = dec_aligned && (dec_index < CHANNEL_COUNT);
        dec_ch      = dec_index[3:0];
        dec_off     = i_paddr[3:2];
    end

    // Read mux; COMMIT and unmapped addresses read as zero.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (dec_chan && (dec_ch == 4'(c))) begin
                case (dec_off)
                    2'd0:    rd_data[FIELD_WIDTH-1:0] = shadow[c];
                    2'd1:    rd_data[FIELD_WIDTH-1:0] = i_status[c];
                    2'd2:    rd_data[FIELD_WIDTH-1:0] = evt[c];
                    default: rd_data[FIELD_WIDTH-1:0] = int_en[c];
                endcase
            end
        end
    end

    // APB FSM: capture request and response on entry, release on exit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= STATE_IDLE;
            req_write  <= 1'b0;
            req_chan   <= 1'b0;
            req_commit <= 1'b0;
            req_ch     <= '0;
            req_off    <= '0;
            req_wdata  <= '0;
            o_prdata   <= '0;
            o_pslverr  <= 1'b0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (i_psel && i_penable) begin
                        state      <= STATE_RESP;
                        req_write  <= i_pwrite;
                        req_chan   <= dec_chan;
                        req_commit <= dec_commit;
                        req_ch     <= dec_ch;
                        req_off    <= dec_off;
                        req_wdata  <= i_pwdata[KEEP_WIDTH-1:0];
                        o_prdata   <= i_pwrite ? 32'h0 : rd_data;
                        o_pslverr  <= !(dec_chan || dec_commit);
                    end
                end
                default: begin
                    state     <= STATE_IDLE;
                    o_prdata  <= '0;
                    o_pslverr <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel write strobes for the edge leaving RESP, plus commit requests.
    always_comb begin
        wr_fire = (state == STATE_RESP) && i_psel && req_write;
        for (int c = 0; c < CHANNELS; c++) begin
            chan_hit[c]   = wr_fire && req_chan && (req_ch == 4'(c));
            wr_ctrl[c]    = chan_hit[c] && (req_off == 2'd0);
            wr_int_en[c]  = chan_hit[c] && (req_off == 2'd3);
            evt_clear[c]  = (chan_hit[c] && (req_off == 2'd2)) ? req_wdata[FIELD_WIDTH-1:0] : '0;
            commit_now[c] = i_commit[c] || (wr_fire && req_commit && req_wdata[c]);
        end
    end

    // Channel registers; commit copies the pre-write shadow, event set beats clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shadow <= {CHANNELS{RESET_VALUE}};
            active <= {CHANNELS{RESET_VALUE}};
            evt    <= '0;
            int_en <= '0;
            o_irq  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (commit_now[c]) begin
                    active[c] <= shadow[c];
                end
                if (wr_ctrl[c]) begin
                    shadow[c] <= req_wdata[FIELD_WIDTH-1:0];
                end
                if (wr_int_en[c]) begin
                    int_en[c] <= req_wdata[FIELD_WIDTH-1:0];
                end
                evt[c]   <= (evt[c] & ~evt_clear[c]) | i_event[c];
                o_irq[c] <= |(evt[c] & int_en[c]);
            end
        end
    end

endmodule

// File: tb/tb_apb_channel_register_bank.sv
// Bench for apb_channel_register_bank: directed scenarios plus a randomized
// register-traffic run against an address-map level model.
module tb_apb_channel_register_bank;

    localparam int CH = 4;
    localparam int FW = 8;
    localparam int AW = 8;
    localparam logic [7:0] RV       = 8'h5A;
    localparam logic [7:0] COMMIT_A = 8'h40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic psel = 1'b0;
    logic penable = 1'b0;
    logic pwrite = 1'b0;
    logic [7:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic pready;
    logic [31:0] prdata;
    logic pslverr;
    logic [3:0][7:0] value;
    logic [3:0][7:0] status_in = '0;
    logic [3:0][7:0] event_in = '0;
    logic [3:0] commit_in = '0;
    logic [3:0] irq;
    logic [0:0] state;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_shadow [4];
    logic [7:0] m_active [4];
    logic [7:0] m_evt [4];
    logic [7:0] m_inten [4];

    apb_channel_register_bank #(
        .CHANNELS(CH), .FIELD_WIDTH(FW), .ADDRESS_WIDTH(AW), .RESET_VALUE(RV)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_pready(pready), .o_prdata(prdata),
        .o_pslverr(pslverr), .o_value(value), .i_status(status_in), .i_event(event_in),
        .i_commit(commit_in), .o_irq(irq), .o_state(state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic exp_err(input logic [7:0] a);
        return (a[1:0] != 2'b00) || (a > COMMIT_A);
    endfunction

    function automatic logic [31:0] exp_read(input logic [7:0] a);
        int c;
        int off;
        logic [7:0] f;
        if (exp_err(a) || a == COMMIT_A) return 32'h0;
        c = int'(a) / 16;
        off = (int'(a) % 16) / 4;
        case (off)
            0: f = m_shadow[c];
            1: f = status_in[c];
            2: f = m_evt[c];
            default: f = m_inten[c];
        endcase
        return {24'h0, f};
    endfunction

    function automatic logic [3:0][7:0] exp_value();
        logic [3:0][7:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_active[c];
        return v;
    endfunction

    function automatic logic [3:0] exp_irq();
        logic [3:0] v;
        for (int c = 0; c < CH; c++) v[c] = |(m_evt[c] & m_inten[c]);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_shadow[c] = RV;
            m_active[c] = RV;
            m_evt[c] = 8'h0;
            m_inten[c] = 8'h0;
        end
    endtask

    // Effect of the edge that completes a transfer (commits first, from old shadow).
    task automatic model_edge(input logic wr, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] cm, input logic [3:0][7:0] ev);
        logic [7:0] clr [4];
        int c;
        for (int i = 0; i < CH; i++) begin
            clr[i] = 8'h0;
            if (cm[i] || (wr && a == COMMIT_A && d[i])) m_active[i] = m_shadow[i];
        end
        if (wr && !exp_err(a) && a != COMMIT_A) begin
            c = int'(a) / 16;
            case ((int'(a) % 16) / 4)
                0: m_shadow[c] = d[7:0];
                2: clr[c] = d[7:0];
                3: m_inten[c] = d[7:0];
                default: ;
            endcase
        end
        for (int i = 0; i < CH; i++) m_evt[i] = (m_evt[i] & ~clr[i]) | ev[i];
    endtask

    // ---------------- drivers ----------------
    // One APB transfer; rdy returns pready sampled in T1, T2, T3.
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input logic [3:0] t2_commit, input logic [31:0] t2_event,
                            output logic [31:0] rdata, output logic err, output logic [2:0] rdy);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(negedge clk);
        rdy[2] = pready;
        penable = 1'b1;
        @(negedge clk);
        rdy[1] = pready;
        rdata = prdata;
        err = pslverr;
        commit_in = t2_commit;
        event_in = t2_event;
        @(negedge clk);
        rdy[0] = pready;
        commit_in = '0;
        event_in = '0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic pulse_event(input logic [31:0] ev);
        @(negedge clk);
        event_in = ev;
        @(negedge clk);
        event_in = '0;
        model_edge(1'b0, 8'h0, 32'h0, 4'h0, ev);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd;
        logic er;
        logic [2:0] rdy;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (pready !== 1'b0) begin n_err++; $display("FAIL reset_pready: got %b required 0", pready); end
        n_cmp++; if (prdata !== 32'h0 || pslverr !== 1'b0) begin n_err++; $display("FAIL reset_resp: got %h/%b required 0/0", prdata, pslverr); end
        n_cmp++; if (state !== 1'b0) begin n_err++; $display("FAIL reset_state: got %b required 0", state); end
        rst = 1'b0;
        model_reset();
        n_cmp++; if (value !== exp_value()) begin n_err++; $display("FAIL reset_value: got %h required %h", value, exp_value()); end
        n_cmp++; if (irq !== 4'h0) begin n_err++; $display("FAIL reset_irq: got %b required 0", irq); end
        status_in = {$urandom};
        for (int a = 0; a <= 64; a += 4) begin
            apb_xfer(1'b0, 8'(a), 32'h0, 4'h0, 32'h0, rd, er, rdy);
            n_cmp++; if (rdy !== 3'b010) begin n_err++; $display("FAIL reset_rd_pready a=%h: got %b required 010", a, rdy); end
            n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL reset_rd_err a=%h: got %b required 0", a, er); end
            n_cmp++; if (rd !== exp_read(8'(a))) begin n_err++; $display("FAIL reset_rd a=%h: got %h required %h", a, rd, exp_read(8'(a))); end
        end
    endtask

    task automatic test_ctrl_commit();
        logic [31:0] rd;
        logic er;
        logic [2:0] rdy;
        logic [31:0] d;
        d = {$urandom_range(0, 32'hFFFFFF), 8'hA5};
        apb_xfer(1'b1, 8'h10, d, 4'h0, 32'h0, rd, er, rdy);
        model_edge(1'b1, 8'h10, d, 4'h0, '0);
        n_cmp++; if (rdy !== 3'b010 || er !== 1'b0) begin n_err++; $display("FAIL ctrl_wr_resp: got %b/%b required 010/0", rdy, er); end
        n_cmp++; if (value[1] !== RV) begin n_err++; $display("FAIL ctrl_no_commit: got %h required %h", value[1], RV); end
        apb_xfer(1'b0, 8'h10, 32'h0, 4'h0, 32'h0, rd, er, rdy);
        n_cmp++; if (rd !== 32'h0000_00A5) begin n_err++; $display("FAIL ctrl_readback: got %h required 000000a5", rd); end
        apb_xfer(1'b1, COMMIT_A, 32'h2, 4'h0, 32'h0, rd, er, rdy);
        model_edge(1'b1, COMMIT_A, 32'h2, 4'h0, '0);
        n_cmp++; if (value !== exp_value()) begin n_err++; $display("FAIL commit_t3: got %h required %h", value, exp_value()); end
        n_cmp++; if (value[1] !== 8'hA5) begin n_err++; $display("FAIL commit_ch1: got %h required a5", value[1]); end
    endtask

    task automatic test_same_cycle_commit();
        logic [31:0] rd;
        logic er;
        logic [2:0] rdy;
        apb_xfer(1'b1, 8'h00, 32'h11, 4'h0, 32'h0, rd, er, rdy);
        model_edge(1'b1, 8'h00, 32'h11, 4'h0, '0);
        apb_xfer(1'b1, 8'h00, 32'h3C, 4'b0001, 32'h0, rd, er, rdy);
        model_edge(1'b1, 8'h00, 32'h3C, 4'b0001, '0);
        n_cmp++; if (value[0] !== 8'h11) begin n_err++; $display("FAIL same_cycle_active: got %h required 11", value[0]); end
        n_cmp++; if (value !== exp_value()) begin n_err++; $display("FAIL same_cycle_others: got %h required %h", value, exp_value()); end
        apb_xfer(1'b0, 8'h00, 32'h0, 4'h0, 32'h0, rd, er, rdy);
        n_cmp++; if (rd !== 32'h3C) begin n_err++; $display("FAIL same_cycle_shadow: got %h required 3c", rd); end
        // Hardware commit alone: visible the cycle after its edge.
        @(negedge clk);
        commit_in = 4'b0001;
        @(negedge clk);
        commit_in = 4'b0000;
        model_edge(1'b0, 8'h0, 32'h0, 4'b0001, '0);
        n_cmp++; if (value[0] !== 8'h3C) begin n_err++; $display("FAIL hw_commit: got %h required 3c", value[0]); end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        logic er;
        logic [2:0] rdy;
        apb_xfer(1'b1, 8'h2C, 32'h01, 4'h0, 32'h0, rd, er, rdy);
        model_edge(1'b1, 8'h2C, 32'h01, 4'h0, '0);
        pulse_event(32'h0001_0000);
        n_cmp++; if (irq[2] !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b required 0", irq[2]); end
        @(negedge clk);
        n_cmp++; if (irq !== exp_irq() || irq[2] !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b required %b", irq, exp_irq()); end
        // W1C racing a new event on the same bit: set wins.
        apb_xfer(1'b1, 8'h28, 32'h01, 4'h0, 32'h0001_0000, rd, er, rdy);
        model_edge(1'b1, 8'h28, 32'h01, 4'h0, 32'h0001_0000);
        apb_xfer(1'b0, 8'h28, 32'h0, 4'h0, 32'h0, rd, er, rdy);
        n_cmp++; if (rd !== 32'h01 || rd !== exp_read(8'h28)) begin n_err++; $display("FAIL w1c_race_event: got %h required 01", rd); end
        n_cmp++; if (irq[2] !== 1'b1) begin n_err++; $display("FAIL w1c_race_irq: got %b required 1", irq[2]); end
        // Plain W1C: irq drops one cycle after T3.
        apb_xfer(1'b1, 8'h28, 32'hFFFF_FF01, 4'h0, 32'h0, rd, er, rdy);
        model_edge(1'b1, 8'h28, 32'hFFFF_FF01, 4'h0, '0);
        n_cmp++; if (irq[2] !== 1'b1) begin n_err++; $display("FAIL w1c_irq_t3: got %b required 1", irq[2]); end
        @(negedge clk);
        n_cmp++; if (irq !== exp_irq() || irq[2] !== 1'b0) begin n_err++; $display("FAIL w1c_irq_clear: got %b required %b", irq, exp_irq()); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er;
        logic [2:0] rdy;
        logic [7:0] bad [4];
        bad[0] = 8'h44; bad[1] = 8'h02; bad[2] = 8'h47; bad[3] = 8'h81;
        for (int i = 0; i < 4; i++) begin
            apb_xfer(1'b1, bad[i], 32'h77, 4'h0, 32'h0, rd, er, rdy);
            model_edge(1'b1, bad[i], 32'h77, 4'h0, '0);
            n_cmp++; if (er !== 1'b1 || rdy !== 3'b010) begin n_err++; $display("FAIL err_wr a=%h: got %b/%b required 1/010", bad[i], er, rdy); end
            apb_xfer(1'b0, bad[i], 32'h0, 4'h0, 32'h0, rd, er, rdy);
            n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL err_rd a=%h: got %b/%h required 1/0", bad[i], er, rd); end
        end
        apb_xfer(1'b1, 8'h14, 32'hEE, 4'h0, 32'h0, rd, er, rdy);
        model_edge(1'b1, 8'h14, 32'hEE, 4'h0, '0);
        n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL status_wr_err: got %b required 0", er); end
        for (int a = 0; a < 64; a += 4) begin
            apb_xfer(1'b0, 8'(a), 32'h0, 4'h0, 32'h0, rd, er, rdy);
            n_cmp++; if (rd !== exp_read(8'(a))) begin n_err++; $display("FAIL err_no_change a=%h: got %h required %h", a, rd, exp_read(8'(a))); end
        end
        n_cmp++; if (value !== exp_value()) begin n_err++; $display("FAIL err_value: got %h required %h", value, exp_value()); end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic er;
        logic [2:0] rdy;
        logic [7:0] a;
        logic wr;
        logic [31:0] d;
        logic [3:0] cm;
        logic [31:0] exp_rd;
        int k;
        for (int it = 0; it < 80; it++) begin
            k = $urandom_range(0, 9);
            if (k < 7) a = 8'($urandom_range(0, 3) * 16 + $urandom_range(0, 3) * 4);
            else if (k == 7) a = COMMIT_A;
            else if (k == 8) a = 8'($urandom_range(17, 63) * 4);
            else a = 8'($urandom_range(0, 255)) | 8'h01;
            wr = 1'($urandom_range(0, 1));
            d = $urandom;
            cm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            status_in = {$urandom};
            exp_rd = exp_read(a);
            apb_xfer(wr, a, d, cm, 32'h0, rd, er, rdy);
            model_edge(wr, a, d, cm, '0);
            n_cmp++; if (rdy !== 3'b010) begin n_err++; $display("FAIL rnd_pready a=%h: got %b required 010", a, rdy); end
            n_cmp++; if (er !== exp_err(a)) begin n_err++; $display("FAIL rnd_err a=%h: got %b required %b", a, er, exp_err(a)); end
            if (!wr) begin
                n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL rnd_read a=%h: got %h required %h", a, rd, exp_rd); end
            end
            n_cmp++; if (value !== exp_value()) begin n_err++; $display("FAIL rnd_value a=%h: got %h required %h", a, value, exp_value()); end
            pulse_event($urandom & $urandom & $urandom);
            @(negedge clk);
            n_cmp++; if (irq !== exp_irq()) begin n_err++; $display("FAIL rnd_irq: got %b required %b", irq, exp_irq()); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic er;
        logic [2:0] rdy;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 32'hC3;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        n_cmp++; if (pready !== 1'b1) begin n_err++; $display("FAIL mid_t2_pready: got %b required 1", pready); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (pready !== 1'b0) begin n_err++; $display("FAIL mid_pready: got %b required 0", pready); end
        n_cmp++; if (state !== 1'b0) begin n_err++; $display("FAIL mid_state: got %b required 0", state); end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rst = 1'b0;
        model_reset();
        apb_xfer(1'b0, 8'h20, 32'h0, 4'h0, 32'h0, rd, er, rdy);
        n_cmp++; if (rd !== {24'h0, RV}) begin n_err++; $display("FAIL mid_shadow: got %h required %h", rd, RV); end
        n_cmp++; if (value !== exp_value() || irq !== 4'h0) begin n_err++; $display("FAIL mid_outputs: got %h/%b required %h/0", value, irq, exp_value()); end
    endtask

    initial begin
        test_reset();
        test_ctrl_commit();
        test_same_cycle_commit();
        test_irq();
        test_errors();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
